// File: rtl/led_pkg.sv
// Shared types and defaults for the LED PWM driver.
package led_pkg;

   localparam int LED_PWM_BITS_DEF = 8;

   typedef enum logic [1:0] {
      ST_OFF = 2'd0,
      ST_ARM = 2'd1,
      ST_RUN = 2'd2
   } led_state_t;

endpackage

// File: rtl/tick_sync.sv
// Two-flop synchronizer for the divided clock plus a registered rising-edge detect.
// A rise sampled at edge k is presented on TICK for the cycle consumed at edge k+3.
module tick_sync (
   input  logic CLKIN,
   input  logic SCLR_L,
   input  logic TICK_IN,
   output logic TICK
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic r_tick;

   always_ff @(posedge CLKIN) begin
      if (!SCLR_L) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_tick  <= 1'b0;
      end else begin
         r_sync1 <= TICK_IN;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_tick  <= r_sync2 & ~r_prev;
      end
   end

   assign TICK = r_tick;

endmodule

// File: rtl/led_pwm_driver.sv
// Multi-channel PWM LED driver: OFF/ARM/RUN engine, shadow/active duty banks, registered compare.
// Shadow duties are copied to active on RUN entry and at every phase wrap; writes stall only in that copy cycle.
module led_pwm_driver
   import led_pkg::*;
#(
   parameter int NLED     = 4,
   parameter int PWM_BITS = LED_PWM_BITS_DEF
) (
   input  logic                     CLKIN,
   input  logic                     SCLR_L,
   input  logic                     TICK_IN,
   input  logic                     EN,
   input  logic                     WR_VALID,
   output logic                     WR_READY,
   input  logic [$clog2(NLED)-1:0]  WR_IDX,
   input  logic [PWM_BITS-1:0]      WR_DUTY,
   output logic [NLED-1:0]          LED_OUT,
   output logic                     FRAME_DONE
);

   localparam logic [PWM_BITS-1:0] PHASE_MAX = '1;

   led_state_t           r_state;
   led_state_t           w_state_nxt;
   logic [PWM_BITS-1:0]  r_phase;
   logic [PWM_BITS-1:0]  w_phase_nxt;
   logic [PWM_BITS-1:0]  r_shadow [NLED];
   logic [PWM_BITS-1:0]  r_active [NLED];
   logic [NLED-1:0]      r_led;
   logic [NLED-1:0]      w_led_cmp;
   logic                 r_frame_done;
   logic                 r_rdy;
   logic                 w_tick;
   logic                 w_copy;
   logic                 w_wrap;
   logic                 w_wr_acc;

   tick_sync u_tick_sync (
      .CLKIN   (CLKIN),
      .SCLR_L  (SCLR_L),
      .TICK_IN (TICK_IN),
      .TICK    (w_tick)
   );

   // Dropping EN always takes priority over a coincident tick.
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_copy      = 1'b0;
      w_wrap      = 1'b0;
      case (r_state)
         ST_OFF: begin
            if (EN) begin
               w_state_nxt = ST_ARM;
            end
         end
         ST_ARM: begin
            if (!EN) begin
               w_state_nxt = ST_OFF;
            end else if (w_tick) begin
               w_state_nxt = ST_RUN;
               w_phase_nxt = '0;
               w_copy      = 1'b1;
            end
         end
         ST_RUN: begin
            if (!EN) begin
               w_state_nxt = ST_OFF;
               w_phase_nxt = '0;
            end else if (w_tick) begin
               w_phase_nxt = r_phase + PWM_BITS'(1);
               if (r_phase == PHASE_MAX) begin
                  w_wrap = 1'b1;
                  w_copy = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_OFF;
            w_phase_nxt = '0;
         end
      endcase
   end

   always_comb begin
      w_led_cmp = '0;
      for (int i = 0; i < NLED; i++) begin
         w_led_cmp[i] = (r_phase < r_active[i]);
      end
   end

   assign WR_READY = r_rdy & ~w_copy;
   assign w_wr_acc = WR_VALID & WR_READY;

   always_ff @(posedge CLKIN) begin
      if (!SCLR_L) begin
         r_state      <= ST_OFF;
         r_phase      <= '0;
         r_led        <= '0;
         r_frame_done <= 1'b0;
         r_rdy        <= 1'b0;
         for (int i = 0; i < NLED; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         r_state      <= w_state_nxt;
         r_phase      <= w_phase_nxt;
         r_frame_done <= w_wrap;
         r_rdy        <= 1'b1;
         // Outputs are forced low on the same edge the engine leaves RUN.
         r_led        <= (r_state == ST_RUN && w_state_nxt == ST_RUN) ? w_led_cmp : '0;
         for (int i = 0; i < NLED; i++) begin
            if (w_copy) begin
               r_active[i] <= r_shadow[i];
            end
         end
         if (w_wr_acc && (int'(WR_IDX) < NLED)) begin
            r_shadow[WR_IDX] <= WR_DUTY;
         end
      end
   end

   assign LED_OUT    = r_led;
   assign FRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Scoreboard bench for led_pwm_driver: a behavioural model predicts LED_OUT, FRAME_DONE and WR_READY each cycle.
module tb_led_pwm_driver;

   localparam int NLED = 5;
   localparam int PW   = 8;
   localparam int IW   = $clog2(NLED);
   localparam int PMAX = (1 << PW) - 1;
   localparam int M_OFF = 0;
   localparam int M_ARM = 1;
   localparam int M_RUN = 2;

   logic            clk = 1'b0;
   logic            sclr_l;
   logic            tick_in;
   logic            en;
   logic            wr_valid;
   logic            wr_ready;
   logic [IW-1:0]   wr_idx;
   logic [PW-1:0]   wr_duty;
   logic [NLED-1:0] led_out;
   logic            frame_done;

   always #5 clk = ~clk;

   led_pwm_driver #(.NLED(NLED), .PWM_BITS(PW)) dut (
      .CLKIN      (clk),
      .SCLR_L     (sclr_l),
      .TICK_IN    (tick_in),
      .EN         (en),
      .WR_VALID   (wr_valid),
      .WR_READY   (wr_ready),
      .WR_IDX     (wr_idx),
      .WR_DUTY    (wr_duty),
      .LED_OUT    (led_out),
      .FRAME_DONE (frame_done)
   );

   typedef struct packed {
      logic [NLED-1:0] led;
      logic            fd;
      logic            rdy;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   tmode = 0;

   // Reference model state
   int              m_mode = M_OFF;
   int              m_phase = 0;
   int              m_shadow [NLED];
   int              m_active [NLED];
   logic [NLED-1:0] m_led = '0;
   bit              m_fd = 0;
   bit              m_rdy_reg = 0;
   bit              m_rdy = 0;
   bit              h [4];
   bit              s_rst, s_en, s_tin, s_v, m_tk, m_cp;
   int              s_idx, s_duty, m_pm, m_pp;
   logic [NLED-1:0] m_lc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
      end
   endtask

   // h[2]/h[3] are the TICK_IN samples three and four edges before the next edge.
   function automatic bit tick_next();
      return h[2] && !h[3];
   endfunction

   initial begin
      foreach (h[i]) h[i] = 0;
      foreach (m_shadow[i]) begin
         m_shadow[i] = 0;
         m_active[i] = 0;
      end
      forever begin
         @(posedge clk);
         s_rst = sclr_l; s_en = en; s_tin = tick_in; s_v = wr_valid;
         s_idx = int'(wr_idx); s_duty = int'(wr_duty);
         if (!s_rst) begin
            m_mode = M_OFF; m_phase = 0; m_led = '0; m_fd = 0; m_rdy_reg = 0;
            foreach (m_shadow[i]) begin
               m_shadow[i] = 0;
               m_active[i] = 0;
            end
            foreach (h[i]) h[i] = 0;
         end else begin
            m_tk = tick_next(); m_pm = m_mode; m_pp = m_phase; m_cp = 0; m_fd = 0;
            for (int i = 0; i < NLED; i++) m_lc[i] = (m_pp < m_active[i]);
            if (m_mode == M_OFF) begin
               if (s_en) m_mode = M_ARM;
            end else if (m_mode == M_ARM) begin
               if (!s_en) m_mode = M_OFF;
               else if (m_tk) begin m_mode = M_RUN; m_phase = 0; m_cp = 1; end
            end else begin
               if (!s_en) begin m_mode = M_OFF; m_phase = 0; end
               else if (m_tk) begin
                  if (m_phase == PMAX) begin m_fd = 1; m_cp = 1; end
                  m_phase = (m_phase + 1) % (PMAX + 1);
               end
            end
            m_led = (m_pm == M_RUN && m_mode == M_RUN) ? m_lc : '0;
            if (m_cp) m_active = m_shadow;
            if (s_v && m_rdy && s_idx < NLED) m_shadow[s_idx] = s_duty;
            m_rdy_reg = 1;
            h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = s_tin;
         end
         #2;
         m_rdy = m_rdy_reg && !(tick_next() && en &&
                 (m_mode == M_ARM || (m_mode == M_RUN && m_phase == PMAX)));
         sb_q.push_back({m_led, m_fd, m_rdy});
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("led_out", 32'(led_out), 32'(e.led));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
            chk("wr_ready", 32'(wr_ready), 32'(e.rdy));
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (tmode == 1) tick_in = ~tick_in;
         else if (tmode == 2) tick_in = 1'($urandom_range(0, 1));
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input int idx, input int duty, output int stalls);
      bit acc = 0;
      wr_valid = 1'b1; wr_idx = IW'(idx); wr_duty = PW'(duty); stalls = 0;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         if (wr_ready === 1'b1) acc = 1;
         else stalls++;
      end
      chk("wr_accept", 32'(acc), 32'd1);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic wait_run_phase(input int p, input bit need_tick, input string nm);
      bit ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (m_mode == M_RUN && m_phase == p && (!need_tick || tick_next())) ok = 1;
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL %s: phase 0x%0h not reached within bound", nm, p);
      end
   endtask

   initial begin
      int st, hi, fdc, r;
      bit got;
      sclr_l = 1'b0; en = 1'b0; tick_in = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_duty = '0;
      cyc(3);
      sclr_l = 1'b1;
      cyc(1);
      wr(0, 'h40, st); wr(2, 'h00, st); wr(3, 'hFF, st); wr(4, 'h20, st); wr(6, 'h77, st);
      tmode = 1; en = 1'b1;

      // Full frame of ch0 at 0x40 with one tick every two cycles
      got = 0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) got = 1;
      end
      chk("first_frame_done", 32'(got), 32'd1);
      hi = 0; fdc = 0;
      repeat (512) begin
         @(negedge clk);
         hi += int'(led_out[0]);
         fdc += int'(frame_done);
      end
      chk("ch0_high_cycles", 32'(hi), 32'd128);
      chk("frames_per_window", 32'(fdc), 32'd1);
      @(posedge clk);
      #1;

      wait_run_phase('h10, 0, "wait_p10");
      wr(1, 'h80, st);
      cyc(1100);

      wait_run_phase(PMAX, 1, "wait_copy");
      wr(4, 'h90, st);
      chk("copy_stall_cycles", 32'(st), 32'd1);
      cyc(1100);

      wait_run_phase('h33, 1, "wait_p33");
      en = 1'b0;
      cyc(6);
      en = 1'b1;
      wait_run_phase('h90, 0, "wait_p90");
      sclr_l = 1'b0;
      cyc(2);
      sclr_l = 1'b1;
      cyc(2);

      wr(0, 'h05, st); wr(3, 'hFF, st); wr(1, 'hC0, st);
      cyc(300);
      tmode = 0;
      cyc(100);
      tmode = 1;
      cyc(50);

      for (int c = 0; c < 4000; c++) begin
         r = $urandom_range(0, 999);
         if (r < 3) begin
            sclr_l = 1'b0; cyc(1); sclr_l = 1'b1;
         end else if (r < 6) begin
            en = ~en; cyc(1);
         end else if (r < 16) begin
            tmode = $urandom_range(0, 2); cyc(1);
         end else if (r < 110) begin
            wr($urandom_range(0, 7), $urandom_range(0, PMAX), st);
         end else begin
            cyc(1);
         end
      end
      cyc(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 Parameter NLED, default 4: number of LED channels, from 2 to 16.
REQ-002 Parameter PWM_BITS, default 8: width of the duty and phase values.
REQ-003 CLKIN  in  1: single system clock; all logic SHALL be rising-edge CLKIN.
REQ-004 SCLR_L  in  1: synchronous, active-low reset, sampled on CLKIN rising edge.
REQ-005 TICK_IN  in  1: divided clock from the clock-divider stage; treated as asynchronous level.
REQ-006 EN  in  1: run enable for the PWM engine.
REQ-007 WR_VALID  in  1: duty-write request.
REQ-008 WR_READY  out  1: duty-write accept.
REQ-009 WR_IDX  in  clog2(NLED): target channel of the write.
REQ-010 WR_DUTY  in  PWM_BITS: duty value to write.
REQ-011 LED_OUT  out  NLED: registered PWM outputs, one bit per channel.
REQ-012 FRAME_DONE  out  1: one-CLKIN pulse at each PWM period wrap.

Function
REQ-013 TICK_IN SHALL pass through a 2-flop synchronizer, followed by a rising-edge detect.
- The detect produces a one-cycle tick.
- A TICK_IN rise sampled at edge k SHALL give tick at k+3.
REQ-014 Phase counter (PWM_BITS):
- increments by 1 per tick in RUN;
- wraps from 2^PWM_BITS-1 to 0;
- holds between ticks.
REQ-015 FSM states:
- OFF -> ARM when EN=1.
- ARM -> RUN on the next tick; phase:=0 and all shadow duties are copied to active in that cycle.
- RUN -> OFF in the cycle after EN=0 is sampled.
REQ-016 In OFF and ARM: LED_OUT SHALL be 0 and phase SHALL be 0.
REQ-017 In RUN: LED_OUT[i] SHALL be registered (phase < active_duty[i]).
- LED_OUT is updated one cycle after the phase changes.
- duty 0 means always off.
- duty 255 (at PWM_BITS=8) means on for 255 of 256 phases.
REQ-018 Write handshake:
- A write is accepted on a cycle with WR_VALID & WR_READY.
- The accepted write updates shadow_duty[WR_IDX] on that edge.
- Active duties SHALL NOT change on a write.
REQ-019 WR_READY SHALL be 1 in every state except the single cycle in which shadow is copied to active.
- In that cycle a pending WR_VALID is stalled.
- WR_IDX and WR_DUTY SHALL be held stable while WR_VALID=1 and WR_READY=0.
REQ-020 WR_IDX >= NLED SHALL be accepted and discarded, with no state change.
REQ-021 At each RUN wrap (phase 2^PWM_BITS-1 -> 0):
- shadow is copied to active in the same cycle as the phase wrap;
- FRAME_DONE pulses for exactly that one cycle.
REQ-022 A write accepted one cycle before the copy cycle SHALL be included in that copy.
REQ-023 EN falling in the same cycle as a tick: the OFF transition wins and the phase SHALL NOT advance.
REQ-024 TICK_IN held constant SHALL produce no ticks, and the outputs SHALL hold.

Reset
REQ-025 On SCLR_L=0 at a CLKIN edge, the following SHALL take their reset values:
- state = OFF;
- phase = 0;
- shadow duties = 0;
- active duties = 0;
- synchronizer and edge flops = 0;
- LED_OUT = 0;
- FRAME_DONE = 0;
- WR_READY = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no FRAME_DONE pulse.
- A write on the reset cycle is dropped.
REQ-027 WR_READY SHALL be 1 from the first edge after SCLR_L returns high.

Structure
REQ-028 The FSM state enum (OFF, ARM, RUN) and the PWM_BITS default SHALL live in shared package led_pkg.
REQ-029 The synchronizer plus edge detect SHALL be a sub-module named tick_sync.
- Ports: CLKIN, SCLR_L, TICK_IN, TICK.
REQ-030 The remaining logic (FSM, counter, duty arrays, compare) SHALL be in led_pwm_driver; target is 120-400 lines of RTL total.

Verification
REQ-031 Write 0x40 to ch0, then EN=1, then 256 ticks:
- LED_OUT[0]=1 for exactly 64 ticks per frame;
- FRAME_DONE pulses once.
REQ-032 Write 0x80 to ch1 while in RUN at phase 0x10:
- LED_OUT[1] is unchanged until the wrap;
- LED_OUT[1] shows 128/256 duty in the next frame.
REQ-033 Hold WR_VALID=1 across the copy cycle:
- WR_READY=0 for exactly 1 cycle;
- the write completes on the next edge and is not lost.
REQ-034 Channel edge duties:
- duty 0x00 on ch2 gives LED_OUT[2] constantly 0;
- duty 0xFF on ch3 gives LED_OUT[3] low only at phase 0xFF.
REQ-035 EN=0 coincident with a tick at phase 0x33, then SCLR_L=0 at phase 0x90 of a later run:
- state goes to OFF and phase goes to 0, with no FRAME_DONE;
- all outputs read 0 on the edge after reset;
- WR_READY reads 0 during reset.
REQ-036 TICK_IN rise sampled at edge k, with EN=1 and ARM state:
- tick at k+3;
- RUN entry and copy at k+3;
- LED_OUT valid at k+4.
